// File: rtl/mul_pkg.sv
// Shared types and constants for the sequential Booth multiplier.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int MUL_ITERS = 32;
    localparam int ACC_W     = 33;

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add/subtract of M into A, then an
// arithmetic right shift of {A, Q, q_m1}.
module booth_step
    import mul_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [ACC_W-1:0] acc,
    input  logic [WIDTH-1:0] q,
    input  logic             q_m1,
    input  logic [ACC_W-1:0] m,
    output logic [ACC_W-1:0] acc_nxt,
    output logic [WIDTH-1:0] q_nxt,
    output logic             q_m1_nxt
);

    logic [ACC_W-1:0] neg_m;
    logic [ACC_W-1:0] sum;

    // 33-bit negation keeps -(-2^31) representable.
    assign neg_m = ~m + {{(ACC_W-1){1'b0}}, 1'b1};

    always_comb begin
        sum = acc;
        unique case ({q[0], q_m1})
            2'b01:   sum = acc + m;
            2'b10:   sum = acc + neg_m;
            default: sum = acc;
        endcase
    end

    assign {acc_nxt, q_nxt, q_m1_nxt} = {sum[ACC_W-1], sum, q};

endmodule

// File: rtl/booth_mul_32bit.sv
// Sequential signed radix-2 Booth multiplier with start/busy/done handshake.
//   state | meaning
//   IDLE  | waiting for start; operands captured on acceptance
//   RUN   | one Booth step per cycle, 32 steps
//   DONE  | product valid, done pulses for one cycle
module booth_mul_32bit
    import mul_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int              CNT_W    = $clog2(MUL_ITERS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_ITERS - 1);

    state_t           state;
    state_t           state_nxt;
    logic [ACC_W-1:0] acc;
    logic [WIDTH-1:0] q;
    logic             q_m1;
    logic [ACC_W-1:0] m;
    logic [CNT_W-1:0] cnt;

    logic [ACC_W-1:0] acc_step;
    logic [WIDTH-1:0] q_step;
    logic             q_m1_step;

    booth_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .acc      (acc),
        .q        (q),
        .q_m1     (q_m1),
        .m        (m),
        .acc_nxt  (acc_step),
        .q_nxt    (q_step),
        .q_m1_nxt (q_m1_step)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (cnt == CNT_LAST) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc     <= '0;
            q       <= '0;
            q_m1    <= 1'b0;
            m       <= '0;
            cnt     <= '0;
            product <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        acc  <= '0;
                        q    <= b;
                        q_m1 <= 1'b0;
                        m    <= {a[WIDTH-1], a};
                        cnt  <= '0;
                    end
                end
                RUN: begin
                    acc  <= acc_step;
                    q    <= q_step;
                    q_m1 <= q_m1_step;
                    cnt  <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                    // The last step's shifted result is the finished product.
                    if (cnt == CNT_LAST) begin
                        product <= {acc_step[WIDTH-1:0], q_step};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mul_32bit.sv
// Scoreboard bench for booth_mul_32bit: directed vectors push expected product
// and done cycle; a monitor pops on every done pulse.
module tb_booth_mul_32bit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [63:0] product;

    typedef struct {
        logic [63:0] prod;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc;
    int   checks;
    int   errors;

    booth_mul_32bit #(.WIDTH(32)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 with product %h, expected no done (cycle %0d)",
                         product, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("product", product, e.prod);
                chk("done_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic drive_start(input logic [31:0] av, input logic [31:0] bv,
                               input logic [63:0] ex, input bit push, output int s);
        exp_t e;
        @(posedge clk);
        #1;
        a     = av;
        b     = bv;
        start = 1'b1;
        s     = cyc;
        if (push) begin
            e.prod = ex;
            e.cyc  = s + 33;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic goto_cyc(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic at_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // Single isolated operation; done cycle and product checked by the monitor.
    task automatic run_one(input logic [31:0] av, input logic [31:0] bv, input logic [63:0] ex);
        int s;
        drive_start(av, bv, ex, 1'b1, s);
        at_cyc(s + 33);
        chk("busy_in_done", 64'(busy), 64'd1);
        at_cyc(s + 34);
        chk("busy_after", 64'(busy), 64'd0);
        at_cyc(s + 36);
    endtask

    initial begin
        int s;
        int s2;
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        a      = '0;
        b      = '0;

        repeat (3) @(negedge clk);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_product", product, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        run_one(32'd3, 32'hFFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1);
        run_one(32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
        run_one(32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001);
        run_one(32'h8000_0000, 32'd1, 64'hFFFF_FFFF_8000_0000);
        run_one(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1);
        run_one(32'hFFFF_FFFF, 32'h7FFF_FFFF, 64'hFFFF_FFFF_8000_0001);
        run_one(32'd0, 32'h1234_5678, 64'd0);

        // start and operand changes during RUN must be ignored.
        drive_start(32'd7, 32'd6, 64'd42, 1'b1, s);
        goto_cyc(s + 9);
        drive_start(32'd1, 32'd1, 64'd0, 1'b0, s2);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            a = 32'(i * 17 + 5);
            b = 32'(i * 3 + 11);
        end
        at_cyc(s + 33);
        chk("ignore_busy_done", 64'(busy), 64'd1);
        at_cyc(s + 34);
        chk("ignore_busy_after", 64'(busy), 64'd0);
        at_cyc(s + 70);
        chk("ignore_no_second_op", 64'(busy), 64'd0);

        // Reset mid-operation aborts without a done pulse.
        drive_start(32'd9, 32'd9, 64'd81, 1'b0, s);
        goto_cyc(s + 11);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        at_cyc(s + 13);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_product", product, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        at_cyc(s + 52);
        chk("abort_idle", 64'(busy), 64'd0);
        chk("abort_product_hold", product, 64'd0);

        // Back-to-back at the minimum issue interval.
        drive_start(32'd2, 32'd3, 64'd6, 1'b1, s);
        goto_cyc(s + 33);
        drive_start(32'hFFFF_FFFC, 32'hFFFF_FFFC, 64'd16, 1'b1, s2);
        chk("b2b_issue_cycle", 64'(s2), 64'(s + 34));
        at_cyc(s + 50);
        chk("b2b_product_hold", product, 64'd6);
        at_cyc(s + 68);
        chk("b2b_busy_after", 64'(busy), 64'd0);
        at_cyc(s + 72);

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation reached time limit, expected completion");
        $fatal(1, "timeout");
    end

endmodule
